instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles every non-clock, non-reset signal of the instruction fetch unit:
//   control from execute, the instruction ROM port and the decode handshake.
//
//   fetch_en_i     fetching permitted
//   redirect_i     branch/jump redirect strobe
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   rom_addr_o     ROM byte address (current PC)
//   rom_en_o       ROM read enable
//   rom_instr_i    ROM data, valid in the same cycle as rom_addr_o
//   id_valid_o     head entry valid for decode
//   id_ready_i     decode accepts the head entry
//   id_instr_o     head entry instruction word
//   id_pc_o        head entry PC
//
//   master : the fetch unit
//   slave  : the surrounding core / ROM / decode
// ---------------------------------------------------------------------------
interface instr_fetch_if;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] rom_addr_o;
    logic        rom_en_o;
    logic [31:0] rom_instr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;

    modport master (
        input  fetch_en_i, redirect_i, redirect_pc_i, rom_instr_i, id_ready_i,
        output rom_addr_o, rom_en_o, id_valid_o, id_instr_o, id_pc_o
    );

    modport slave (
        output fetch_en_i, redirect_i, redirect_pc_i, rom_instr_i, id_ready_i,
        input  rom_addr_o, rom_en_o, id_valid_o, id_instr_o, id_pc_o
    );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit: drives the PC onto a combinational-read ROM and
//   buffers {pc, instr} pairs in a small FIFO feeding decode. A redirect
//   flushes the buffer and reloads the PC in one edge.
//
//   Parameters
//     BOOT_ADDR  reset PC (bits [1:0] forced to zero)
//     DEPTH      fetch-buffer entries, 2 or 4
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        instr_fetch_if.master (control, ROM port, decode handshake)
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no fetching; buffered entries still drain
//   FETCH | one ROM read per cycle while the buffer has room
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [31:0]   BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   shift_pc    [DEPTH];
    logic [31:0]   shift_instr [DEPTH];
    logic          push;
    logic          pop;
    logic          pop_eff;
    logic [CW-1:0] wr_idx;
    logic          unused_rpc_lsb;

    // Word alignment of the redirect target discards the low bits.
    assign unused_rpc_lsb = ^bus.redirect_pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        pop_eff   = 1'b0;
        push      = 1'b0;
        wr_idx    = count;

        case (state)
            IDLE:    if (bus.fetch_en_i && !bus.redirect_i) state_nxt = FETCH;
            FETCH:   if (!bus.fetch_en_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        pop = (count != '0) && bus.id_ready_i;
        // A redirect discards the buffer, so a concurrent pop has no effect.
        pop_eff = pop && !bus.redirect_i;
        // count never exceeds FULL, so "not below FULL" means exactly full.
        push = (state == FETCH) && !bus.redirect_i && ((count < FULL) || pop);

        // With a pop the whole queue slides down one slot before the write.
        if (pop_eff) wr_idx = count - CW'(1);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_mid
            assign shift_pc[g]    = buf_pc[g+1];
            assign shift_instr[g] = buf_instr[g+1];
        end else begin : g_last
            assign shift_pc[g]    = '0;
            assign shift_instr[g] = '0;
        end
    end

    // Slot 0 is the head. Slots are only rewritten when they receive data or
    // slide, so the head holds its last value when the buffer empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (CW'(i) == wr_idx)) begin
                    buf_pc[i]    <= pc;
                    buf_instr[i] <= bus.rom_instr_i;
                end else if (pop_eff && (CW'(i + 1) < count)) begin
                    buf_pc[i]    <= shift_pc[i];
                    buf_instr[i] <= shift_instr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pc    <= BOOT_PC;
        end else if (bus.redirect_i) begin
            count <= '0;
            pc    <= {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            if (push && !pop_eff) begin
                count <= count + CW'(1);
            end else if (pop_eff && !push) begin
                count <= count - CW'(1);
            end
            if (push) pc <= pc + 32'd4;
        end
    end

    assign bus.rom_addr_o = pc;
    assign bus.rom_en_o   = push;
    assign bus.id_valid_o = (count != '0);
    assign bus.id_instr_o = buf_instr[0];
    assign bus.id_pc_o    = buf_pc[0];

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch (BOOT_ADDR=0, DEPTH=2). Stimulus pushes
//   the expected {pc, instr} stream into a scoreboard queue; a monitor pops
//   and compares on every accepted decode handshake. Control outputs are
//   checked directly at fixed points of the schedule.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .BOOT_ADDR (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM model: words 0..3 hold 0x11,0x22,0x33,0x44, everything else ~addr.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
        return ~a;
    endfunction

    always_comb bus.rom_instr_i = rom_word(bus.rom_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic push_exp(input logic [31:0] p);
        sb.push_back({p, rom_word(p)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per accepted handshake (redirect cancels it).
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.id_valid_o && bus.id_ready_i && !bus.redirect_i) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got pc %h with no entry expected", bus.id_pc_o);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", bus.id_pc_o, e[63:32]);
                    chk("sb_instr", bus.id_instr_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n             = 1'b1;
        bus.fetch_en_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.id_ready_i    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_valid", bus.id_valid_o, 1'b0);
        chk1("rst_rom_en", bus.rom_en_o, 1'b0);
        chk("rst_addr", bus.rom_addr_o, 32'h0);
        chk("rst_instr", bus.id_instr_o, 32'h0);
        chk("rst_pc", bus.id_pc_o, 32'h0);
        step();
        step();

        // Boot stream
        rst_n          = 1'b1;
        bus.fetch_en_i = 1'b1;
        bus.id_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(32'(4 * k));
        step();
        chk1("boot_fetch_rom_en", bus.rom_en_o, 1'b1);
        chk1("boot_no_valid_yet", bus.id_valid_o, 1'b0);
        chk("boot_addr", bus.rom_addr_o, 32'h0);
        step();
        chk1("boot_latency_valid", bus.id_valid_o, 1'b1);
        chk("boot_first_pc", bus.id_pc_o, 32'h0);
        chk("boot_first_instr", bus.id_instr_o, 32'h11);
        for (int k = 1; k < 4; k++) begin
            step();
            chk1("boot_thru_valid", bus.id_valid_o, 1'b1);
            chk("boot_thru_pc", bus.id_pc_o, 32'(4 * k));
        end

        // Fill the buffer, then redirect while full
        bus.id_ready_i = 1'b0;
        step();
        chk1("full_rom_en", bus.rom_en_o, 1'b0);
        chk("full_pc_hold", bus.rom_addr_o, 32'h14);
        chk1("full_valid", bus.id_valid_o, 1'b1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0043;
        bus.id_ready_i    = 1'b1;
        #1;
        chk1("redir_rom_en", bus.rom_en_o, 1'b0);
        step();
        bus.redirect_i = 1'b0;
        sb.delete();
        for (int k = 0; k < 4; k++) push_exp(32'h40 + 32'(4 * k));
        chk1("redir_valid_drop", bus.id_valid_o, 1'b0);
        chk("redir_addr", bus.rom_addr_o, 32'h40);
        step();
        chk("redir_first_pc", bus.id_pc_o, 32'h40);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("redir_stream_pc", bus.id_pc_o, 32'h40 + 32'(4 * k));
        end

        // Wrap at the top of the address space
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        step();
        bus.redirect_i = 1'b0;
        sb.delete();
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        push_exp(32'h4);
        chk1("wrap_valid_drop", bus.id_valid_o, 1'b0);
        chk("wrap_addr", bus.rom_addr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc_top", bus.id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr_zero", bus.rom_addr_o, 32'h0);
        step();
        chk("wrap_pc_zero", bus.id_pc_o, 32'h0);

        // Stop with one entry buffered
        bus.fetch_en_i = 1'b0;
        step();
        chk1("stop_rom_en", bus.rom_en_o, 1'b0);
        chk1("stop_valid", bus.id_valid_o, 1'b1);
        chk("stop_pc", bus.id_pc_o, 32'h4);
        step();
        chk1("stop_drained", bus.id_valid_o, 1'b0);
        chk("stop_pc_hold", bus.id_pc_o, 32'h4);
        chk("stop_sb_empty", 32'(sb.size()), 32'h0);

        // Async reset mid-stream with two entries buffered
        bus.id_ready_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_valid", bus.id_valid_o, 1'b0);
        chk1("arst_rom_en", bus.rom_en_o, 1'b0);
        chk("arst_addr", bus.rom_addr_o, 32'h0);
        chk("arst_pc", bus.id_pc_o, 32'h0);
        step();
        sb.delete();
        rst_n = 1'b1;

        // Backpressure from boot for five cycles
        repeat (5) step();
        chk1("bp_rom_en", bus.rom_en_o, 1'b0);
        chk("bp_pc_hold", bus.rom_addr_o, 32'h8);
        chk1("bp_valid", bus.id_valid_o, 1'b1);
        chk("bp_head_pc", bus.id_pc_o, 32'h0);
        for (int k = 0; k < 6; k++) push_exp(32'(4 * k));
        bus.id_ready_i = 1'b1;
        #1;
        chk1("bp_full_pop_rom_en", bus.rom_en_o, 1'b1);
        repeat (3) step();
        bus.fetch_en_i = 1'b0;
        repeat (5) step();
        chk("bp_sb_empty", 32'(sb.size()), 32'h0);
        chk1("bp_end_valid", bus.id_valid_o, 1'b0);
        chk("bp_end_pc_hold", bus.id_pc_o, 32'h14);
        chk("bp_end_addr", bus.rom_addr_o, 32'h18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
